// File: rtl/jelly3_tdc_encoder.sv
// Carry-chain TDC back end: double-flop the raw taps, repair bubbles, count taps,
// and hand one measurement per arm request out over a valid/ready port.
module jelly3_tdc_encoder #(
  parameter int    TAP_BITS     = 64,
  parameter int    COUNT_BITS   = $clog2(TAP_BITS + 1),
  parameter int    TIMEOUT      = 255,
  parameter int    TIMEOUT_BITS = $clog2(TIMEOUT + 1),
  parameter string DEVICE       = "RTL",
  parameter string SIMULATION   = "false",
  parameter string DEBUG        = "false"
) (
  input  logic                  reset,
  input  logic                  clk,
  input  logic                  cke,
  input  logic [TAP_BITS-1:0]   tap_bits,
  input  logic                  s_arm,
  output logic                  s_ready,
  output logic [COUNT_BITS-1:0] m_count,
  output logic                  m_overflow,
  output logic                  m_timeout,
  output logic                  m_valid,
  input  logic                  m_ready
);

  typedef enum logic [1:0] {ST_IDLE, ST_FLUSH, ST_ARMED, ST_HOLD} state_t;

  // Synchronizer flops carry placement attributes only on real devices or when debugging.
  localparam bit SYNC_ATTR = ((DEVICE != "RTL") && (SIMULATION != "true")) || (DEBUG == "true");

  logic [TAP_BITS-1:0] syn_w;

  generate
    if (SYNC_ATTR) begin : g_sync_attr
      (* ASYNC_REG = "TRUE" *) logic [TAP_BITS-1:0] cap_q;
      (* ASYNC_REG = "TRUE" *) logic [TAP_BITS-1:0] syn_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cap_q <= '0;
          syn_q <= '0;
        end else if (cke) begin
          cap_q <= tap_bits;
          syn_q <= cap_q;
        end
      end
      assign syn_w = syn_q;
    end else begin : g_sync_plain
      logic [TAP_BITS-1:0] cap_q;
      logic [TAP_BITS-1:0] syn_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cap_q <= '0;
          syn_q <= '0;
        end else if (cke) begin
          cap_q <= tap_bits;
          syn_q <= cap_q;
        end
      end
      assign syn_w = syn_q;
    end
  endgenerate

  // Chain input side is implicitly 1, far end implicitly 0.
  logic [TAP_BITS+1:0] syn_ext;
  logic [TAP_BITS-1:0] cor_d;
  logic [TAP_BITS-1:0] cor_q;
  assign syn_ext = {1'b0, syn_w, 1'b1};

  genvar gi;
  generate
    for (gi = 0; gi < TAP_BITS; gi++) begin : g_bubble
      assign cor_d[gi] = (syn_ext[gi] & syn_ext[gi+1]) | (syn_ext[gi] & syn_ext[gi+2])
                       | (syn_ext[gi+1] & syn_ext[gi+2]);
    end
  endgenerate

  logic [COUNT_BITS-1:0] cnt_d;
  logic [COUNT_BITS-1:0] cnt_q;
  logic                  hit_q;
  logic                  full_q;

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < TAP_BITS; i++) begin
      cnt_d = cnt_d + COUNT_BITS'(cor_q[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cor_q  <= '0;
      cnt_q  <= '0;
      hit_q  <= 1'b0;
      full_q <= 1'b0;
    end else if (cke) begin
      cor_q  <= cor_d;
      cnt_q  <= cnt_d;
      hit_q  <= cor_q[0];
      full_q <= &cor_q;
    end
  end

  state_t                  state_q, state_d;
  logic [1:0]              flush_q, flush_d;
  logic [TIMEOUT_BITS-1:0] tmo_q, tmo_d;
  logic [COUNT_BITS-1:0]   count_q, count_d;
  logic                    ovf_q, ovf_d;
  logic                    tout_q, tout_d;
  logic                    valid_q, valid_d;

  always_comb begin
    state_d = state_q;
    flush_d = flush_q;
    tmo_d   = tmo_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    tout_d  = tout_q;
    valid_d = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (s_arm) begin
          state_d = ST_FLUSH;
          flush_d = 2'd3;
        end
      end
      ST_FLUSH: begin
        // Three enabled cycles push out samples taken before the arm.
        if (flush_q == 2'd1) begin
          state_d = ST_ARMED;
          tmo_d   = '0;
        end else begin
          flush_d = flush_q - 2'd1;
        end
      end
      ST_ARMED: begin
        if (hit_q) begin
          count_d = cnt_q;
          ovf_d   = full_q;
          tout_d  = 1'b0;
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end else if (tmo_q == TIMEOUT_BITS'(TIMEOUT - 1)) begin
          count_d = '0;
          ovf_d   = 1'b0;
          tout_d  = 1'b1;
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (m_ready) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      flush_q <= '0;
      tmo_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      tout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else if (cke) begin
      state_q <= state_d;
      flush_q <= flush_d;
      tmo_q   <= tmo_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      tout_q  <= tout_d;
      valid_q <= valid_d;
    end
  end

  assign s_ready    = (state_q == ST_IDLE);
  assign m_count    = count_q;
  assign m_overflow = ovf_q;
  assign m_timeout  = tout_q;
  assign m_valid    = valid_q;

endmodule
